// File: rtl/d2_useq_ctrl.sv
// d2_useq_ctrl: decode-stage-2 micro-sequencer.
//
// Each cycle it picks the next control-store address from one of three sources:
// the D1 decode address, the next-uop field of the current uop, or the
// interrupt vector. It also owns the D1->D2 accept handshake (de_ready) and the
// D2->AG valid/stall handshake (d2_valid / ag_stall).
//
// Optional build macro: USEQ_PERF_CNT_EN adds the perf_instr_cnt and
// perf_uop_cnt outputs.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   de_valid, decode_address, opcode_size_in, de_ready   D1 handshake
//   cs_next_addr, cs_ucode_end                           control-store feedback
//   int_pending, int_vector_addr, int_ack                interrupt entry
//   ag_stall, flush                                      downstream control
//   cs_addr, cs_opcode_size, cs_addr_sel, d2_valid,
//   uop_idx, in_int_seq                                  issued uop
//   useq_overrun                                         sticky overrun flag
//
// State table:
//   IDLE         | no valid uop on cs_addr
//   ACTIVE_INSTR | cs_addr holds a uop of a decoded instruction
//   ACTIVE_INT   | cs_addr holds a uop of an interrupt sequence
module d2_useq_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int MAX_UOPS = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              de_valid,
    input  logic [ADDR_W-1:0] decode_address,
    input  logic              opcode_size_in,
    output logic              de_ready,
    input  logic [ADDR_W-1:0] cs_next_addr,
    input  logic              cs_ucode_end,
    input  logic              int_pending,
    input  logic [ADDR_W-1:0] int_vector_addr,
    output logic              int_ack,
    input  logic              ag_stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] cs_addr,
    output logic              cs_opcode_size,
    output logic [1:0]        cs_addr_sel,
    output logic              d2_valid,
    output logic [CNT_W-1:0]  uop_idx,
    output logic              in_int_seq,
`ifdef USEQ_PERF_CNT_EN
    output logic [31:0]       perf_instr_cnt,
    output logic [31:0]       perf_uop_cnt,
`endif
    output logic              useq_overrun
);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        ACTIVE_INSTR = 2'b01,
        ACTIVE_INT   = 2'b10
    } state_t;

    localparam logic [1:0] SEL_DECODE = 2'b00;
    localparam logic [1:0] SEL_NEXT   = 2'b01;
    localparam logic [1:0] SEL_INT    = 2'b10;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              opsz_nxt;
    logic [1:0]        sel_nxt;
    logic [CNT_W-1:0]  idx_nxt;
    logic              overrun_nxt;

    logic advance, mid_seq, at_limit, seq_go, overrun_hit;
    logic take_int, take_instr;

    assign d2_valid   = (state != IDLE);
    assign in_int_seq = (state == ACTIVE_INT);

    assign advance  = !ag_stall || !d2_valid;
    assign mid_seq  = d2_valid && !cs_ucode_end;
    assign at_limit = (uop_idx == CNT_W'(MAX_UOPS - 1));
    // A sequence that has hit the uop limit is treated as ended, so the
    // boundary rules (interrupt / new instruction / idle) take over.
    assign seq_go      = mid_seq && !at_limit;
    assign overrun_hit = !flush && advance && mid_seq && at_limit;
    assign take_int    = !flush && advance && !seq_go && int_pending;
    assign take_instr  = !flush && advance && !seq_go && !int_pending && de_valid;

    // Gated with reset so nothing is accepted or acknowledged while held in reset.
    assign de_ready = reset && take_instr;
    assign int_ack  = reset && take_int;

    always_comb begin
        state_nxt   = state;
        addr_nxt    = cs_addr;
        opsz_nxt    = cs_opcode_size;
        sel_nxt     = cs_addr_sel;
        idx_nxt     = uop_idx;
        overrun_nxt = useq_overrun || overrun_hit;
        if (flush) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else if (!advance) begin
            state_nxt = state;
        end else if (seq_go) begin
            addr_nxt = cs_next_addr;
            sel_nxt  = SEL_NEXT;
            idx_nxt  = uop_idx + CNT_W'(1);
        end else if (int_pending) begin
            state_nxt = ACTIVE_INT;
            addr_nxt  = int_vector_addr;
            sel_nxt   = SEL_INT;
            idx_nxt   = '0;
        end else if (de_valid) begin
            state_nxt = ACTIVE_INSTR;
            addr_nxt  = decode_address;
            opsz_nxt  = opcode_size_in;
            sel_nxt   = SEL_DECODE;
            idx_nxt   = '0;
        end else begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            cs_addr        <= '0;
            cs_opcode_size <= 1'b0;
            cs_addr_sel    <= 2'b00;
            uop_idx        <= '0;
            useq_overrun   <= 1'b0;
        end else begin
            state          <= state_nxt;
            cs_addr        <= addr_nxt;
            cs_opcode_size <= opsz_nxt;
            cs_addr_sel    <= sel_nxt;
            uop_idx        <= idx_nxt;
            useq_overrun   <= overrun_nxt;
        end
    end

`ifdef USEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_instr_cnt <= '0;
            perf_uop_cnt   <= '0;
        end else begin
            if (take_instr)
                perf_instr_cnt <= perf_instr_cnt + 32'd1;
            if (d2_valid && !ag_stall)
                perf_uop_cnt <= perf_uop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/d2_useq_ctrl.md
Name: d2_useq_ctrl

Overview:
Micro-sequencer for decode stage 2. Each cycle it selects the control-store address from three sources:
- the decode address of a new instruction,
- the next-micro-op address returned by the control store,
- an interrupt vector address.

It also owns the D1→D2 accept handshake and the D2→AG valid/stall handshake, so multi-uop instructions and interrupt entry are issued one uop per cycle without dropping or duplicating uops.

Parameters:
ADDR_W, 8, width of control-store address (matches decode_address).
MAX_UOPS, 8, maximum uops per instruction before forced termination.
CNT_W, 4, width of uop index counter; must satisfy 2^CNT_W > MAX_UOPS.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset.
de_valid  in  1  D1 presents a decoded instruction.
decode_address  in  ADDR_W  first-uop control-store address for the D1 instruction.
opcode_size_in  in  1  one/two-byte opcode flag from D1.
de_ready  out  1  D2 accepts the D1 instruction this cycle (combinational).
cs_next_addr  in  ADDR_W  next-uop address field of the currently issued uop.
cs_ucode_end  in  1  currently issued uop is the last of its sequence.
int_pending  in  1  interrupt/exception request level.
int_vector_addr  in  ADDR_W  control-store entry of the interrupt handler sequence.
int_ack  out  1  one-cycle pulse: interrupt sequence taken.
ag_stall  in  1  AG cannot accept a uop this cycle.
flush  in  1  pipeline flush (branch/exception redirect).
cs_addr  out  ADDR_W  registered control-store address of the issued uop.
cs_opcode_size  out  1  registered opcode_size accompanying cs_addr.
cs_addr_sel  out  2  source of cs_addr: 00 decode, 01 next-uop, 10 interrupt, 11 unused.
d2_valid  out  1  registered; cs_addr holds a valid uop for AG.
uop_idx  out  CNT_W  index of the issued uop within its instruction (0 = first).
in_int_seq  out  1  issued uop belongs to an interrupt sequence.
useq_overrun  out  1  sticky; set when MAX_UOPS is exceeded.

Behaviour:
- States:
  - IDLE: no valid uop.
  - ISSUE: valid uop, last or single.
  - SEQ: valid uop with more to follow, i.e. cs_ucode_end=0.
  - State is derived from d2_valid and cs_ucode_end; implement as an explicit 2-bit register IDLE/ACTIVE_INSTR/ACTIVE_INT.
- advance = !ag_stall | !d2_valid. A bubble never blocks.
- mid_seq = d2_valid & !cs_ucode_end.
- On a rising edge, priority from highest to lowest:
  1. Reset low: all registered outputs go to 0, state IDLE, useq_overrun cleared.
  2. Flush: d2_valid←0, state←IDLE, uop_idx←0, in_int_seq←0. de_ready=0 that cycle. No instruction is accepted; int_ack is suppressed.
  3. !advance: hold every registered output. de_ready=0, int_ack=0.
  4. advance & mid_seq: cs_addr←cs_next_addr, sel=01, uop_idx←uop_idx+1, in_int_seq held. de_ready=0. Interrupts are only taken on instruction boundaries.
  5. advance & !mid_seq & int_pending: cs_addr←int_vector_addr, sel=10, d2_valid←1, uop_idx←0, in_int_seq←1, int_ack=1 (combinational, same cycle). de_ready=0.
  6. advance & !mid_seq & de_valid: de_ready=1, cs_addr←decode_address, cs_opcode_size←opcode_size_in, sel=00, d2_valid←1, uop_idx←0, in_int_seq←0.
  7. Otherwise: d2_valid←0, state IDLE.
- Overrun: if rule 4 fires while uop_idx == MAX_UOPS-1:
  - useq_overrun←1 (sticky until reset);
  - the next uop is not issued; the sequence is treated as ended, so rules 5–7 apply instead.
- The next-uop chain wraps modulo 2^ADDR_W; no range check.
- Latency: decode_address accepted in cycle N appears on cs_addr/d2_valid in cycle N+1.
- Zero-bubble behaviour: back-to-back single-uop instructions issue every cycle.
- The de_valid/de_ready handshake is lossless: D1 must hold its inputs while de_ready=0.
- Reset deasserted mid-operation: resume from IDLE. Any in-flight sequence is discarded.

Optional Feature:
USEQ_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_instr_cnt[31:0]: increments on each rule-6 acceptance;
  - perf_uop_cnt[31:0]: increments each cycle d2_valid & !ag_stall.
- Both counters clear on reset, are not cleared by flush, and wrap at 2^32.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Single-uop stream: de_valid=1 with addresses 0x10, 0x11, 0x12, cs_ucode_end=1 → cs_addr 0x10/0x11/0x12 on consecutive cycles, sel=00, de_ready=1 each cycle, uop_idx=0.
2. Three-uop instruction at 0x20, cs_next_addr 0x21 then 0x22, end on 0x22 → cs_addr 0x20, 0x21, 0x22. de_ready=0 for 2 cycles. uop_idx 0, 1, 2. Next instruction issues the following cycle.
3. ag_stall=1 for 3 cycles during uop 0x21 → cs_addr holds 0x21, uop_idx holds 1, no de_ready. Resumes with 0x22.
4. int_pending=1 asserted mid-sequence → int_ack only after end-of-sequence uop. cs_addr=int_vector_addr (0xE0), sel=10, in_int_seq=1. A pending de_valid is not accepted that cycle.
5. flush during uop 0x21 of a sequence → next cycle d2_valid=0, IDLE. A subsequent de_valid with 0x30 issues normally with uop_idx=0.
6. Endless chain (cs_ucode_end=0 always), MAX_UOPS=8 → 8 uops issued (uop_idx 0..7), then useq_overrun=1. Next D1 instruction is accepted. reset low clears useq_overrun.
